// File: rtl/axi_ss_bridge.sv
// axi_ss_bridge
//   AXI4 slave that turns every AXI beat into one transaction on the simple
//   peripheral bus (req/gnt/rvalid). One read or write burst is serviced at a
//   time, with one beat outstanding on the peripheral side.
// Ports
//   clk, reset        : clock, asynchronous active-high reset
//   S_AXI_AW*/W*/B*   : AXI write address, data and response channels
//   S_AXI_AR*/R*      : AXI read address and data channels
//   ss_req/we/be/addr/wdata : registered peripheral request, held until ss_gnt
//   ss_gnt            : request accepted this cycle
//   ss_rvalid/rdata/err : peripheral response, used only while waiting for it
module axi_ss_bridge #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] S_AXI_AWADDR,
  input  logic [7:0]    S_AXI_AWLEN,
  input  logic [2:0]    S_AXI_AWSIZE,
  input  logic [1:0]    S_AXI_AWBURST,
  input  logic          S_AXI_AWVALID,
  output logic          S_AXI_AWREADY,
  input  logic [DW-1:0] S_AXI_WDATA,
  input  logic [3:0]    S_AXI_WSTRB,
  input  logic          S_AXI_WLAST,
  input  logic          S_AXI_WVALID,
  output logic          S_AXI_WREADY,
  output logic [1:0]    S_AXI_BRESP,
  output logic          S_AXI_BVALID,
  input  logic          S_AXI_BREADY,
  input  logic [AW-1:0] S_AXI_ARADDR,
  input  logic [7:0]    S_AXI_ARLEN,
  input  logic [2:0]    S_AXI_ARSIZE,
  input  logic [1:0]    S_AXI_ARBURST,
  input  logic          S_AXI_ARVALID,
  output logic          S_AXI_ARREADY,
  output logic [DW-1:0] S_AXI_RDATA,
  output logic [1:0]    S_AXI_RRESP,
  output logic          S_AXI_RLAST,
  output logic          S_AXI_RVALID,
  input  logic          S_AXI_RREADY,
  output logic          ss_req,
  output logic          ss_we,
  output logic [3:0]    ss_be,
  output logic [AW-1:0] ss_addr,
  output logic [DW-1:0] ss_wdata,
  input  logic          ss_gnt,
  input  logic          ss_rvalid,
  input  logic [DW-1:0] ss_rdata,
  input  logic          ss_err
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, RD_OUT, WR_DATA, WR_REQ, WR_WAIT, WR_RESP
  } state_t;

  state_t        state;
  logic          rd_pri;   // 1: read wins a simultaneous AR/AW request
  logic [7:0]    cnt;      // beats remaining after the current one
  logic [1:0]    burst;
  logic          sticky;   // any beat of the current write saw ss_err
  logic [AW-1:0] next_addr;
  logic          wr_err;
  logic          ar_hs, aw_hs;

  // Size and WLAST carry no information here: beats are always 32-bit and
  // the beat count comes from AWLEN.
  logic unused_ok;
  assign unused_ok = ^{S_AXI_AWSIZE, S_AXI_ARSIZE, S_AXI_WLAST};

  assign S_AXI_ARREADY = (state == IDLE) && S_AXI_ARVALID && (rd_pri || !S_AXI_AWVALID);
  assign S_AXI_AWREADY = (state == IDLE) && S_AXI_AWVALID && (!rd_pri || !S_AXI_ARVALID);
  assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;
  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;

  // FIXED holds the address; INCR and WRAP both step by one word and wrap
  // naturally at 2^AW.
  assign next_addr = (burst == 2'b00) ? ss_addr : ss_addr + AW'(4);
  assign wr_err    = sticky | ss_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      rd_pri       <= 1'b1;
      cnt          <= '0;
      burst        <= '0;
      sticky       <= 1'b0;
      ss_req       <= 1'b0;
      ss_we        <= 1'b0;
      ss_be        <= '0;
      ss_addr      <= '0;
      ss_wdata     <= '0;
      S_AXI_WREADY <= 1'b0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= '0;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RDATA  <= '0;
      S_AXI_RRESP  <= '0;
      S_AXI_RLAST  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ar_hs) begin
            ss_addr <= S_AXI_ARADDR;
            cnt     <= S_AXI_ARLEN;
            burst   <= S_AXI_ARBURST;
            rd_pri  <= 1'b0;
            ss_req  <= 1'b1;
            ss_we   <= 1'b0;
            ss_be   <= 4'hF;
            state   <= RD_REQ;
          end else if (aw_hs) begin
            ss_addr      <= S_AXI_AWADDR;
            cnt          <= S_AXI_AWLEN;
            burst        <= S_AXI_AWBURST;
            rd_pri       <= 1'b1;
            S_AXI_WREADY <= 1'b1;
            state        <= WR_DATA;
          end
        end
        RD_REQ: if (ss_gnt) begin
          ss_req <= 1'b0;
          state  <= RD_WAIT;
        end
        RD_WAIT: if (ss_rvalid) begin
          S_AXI_RDATA  <= ss_rdata;
          S_AXI_RRESP  <= ss_err ? 2'b10 : 2'b00;
          S_AXI_RVALID <= 1'b1;
          S_AXI_RLAST  <= (cnt == 8'd0);
          state        <= RD_OUT;
        end
        RD_OUT: if (S_AXI_RREADY) begin
          S_AXI_RVALID <= 1'b0;
          S_AXI_RLAST  <= 1'b0;
          if (S_AXI_RLAST) begin
            state <= IDLE;
          end else begin
            cnt     <= cnt - 8'd1;
            ss_addr <= next_addr;
            ss_req  <= 1'b1;
            state   <= RD_REQ;
          end
        end
        WR_DATA: if (S_AXI_WVALID) begin
          S_AXI_WREADY <= 1'b0;
          ss_wdata     <= S_AXI_WDATA;
          ss_be        <= S_AXI_WSTRB;
          ss_we        <= 1'b1;
          ss_req       <= 1'b1;
          state        <= WR_REQ;
        end
        WR_REQ: if (ss_gnt) begin
          ss_req <= 1'b0;
          state  <= WR_WAIT;
        end
        WR_WAIT: if (ss_rvalid) begin
          sticky <= wr_err;
          if (cnt == 8'd0) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_err ? 2'b10 : 2'b00;
            state        <= WR_RESP;
          end else begin
            cnt          <= cnt - 8'd1;
            ss_addr      <= next_addr;
            S_AXI_WREADY <= 1'b1;
            state        <= WR_DATA;
          end
        end
        WR_RESP: if (S_AXI_BREADY) begin
          S_AXI_BVALID <= 1'b0;
          sticky       <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ss_bridge.sv
// Directed bench for axi_ss_bridge: an AXI master driven from tasks and a
// peripheral responder that grants in the request cycle and answers one
// cycle later, logging every request it accepts.
module tb_axi_ss_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TMO = 60;
  localparam logic [1:0] FIXED = 2'b00, INCR = 2'b01;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [AW-1:0] S_AXI_AWADDR, S_AXI_ARADDR, ss_addr;
  logic [7:0]    S_AXI_AWLEN, S_AXI_ARLEN;
  logic [2:0]    S_AXI_AWSIZE, S_AXI_ARSIZE;
  logic [1:0]    S_AXI_AWBURST, S_AXI_ARBURST, S_AXI_BRESP, S_AXI_RRESP;
  logic          S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WLAST, S_AXI_WVALID, S_AXI_WREADY;
  logic          S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic          S_AXI_RLAST, S_AXI_RVALID, S_AXI_RREADY;
  logic [DW-1:0] S_AXI_WDATA, S_AXI_RDATA, ss_wdata, ss_rdata;
  logic [3:0]    S_AXI_WSTRB, ss_be;
  logic          ss_req, ss_we, ss_gnt, ss_rvalid, ss_err;

  axi_ss_bridge #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN), .S_AXI_AWSIZE(S_AXI_AWSIZE),
    .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN), .S_AXI_ARSIZE(S_AXI_ARSIZE),
    .S_AXI_ARBURST(S_AXI_ARBURST), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .ss_req(ss_req), .ss_we(ss_we), .ss_be(ss_be), .ss_addr(ss_addr), .ss_wdata(ss_wdata),
    .ss_gnt(ss_gnt), .ss_rvalid(ss_rvalid), .ss_rdata(ss_rdata), .ss_err(ss_err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // ---------------- peripheral responder ----------------
  int          n_req = 0;
  logic [31:0] log_addr [512];
  logic [31:0] log_wdata[512];
  logic [3:0]  log_be   [512];
  logic        log_we   [512];
  logic [31:0] rd_tab   [16];
  int          err_at = -1;
  logic        rv_en = 1'b1;

  initial begin : resp
    int cur;
    bit pend;
    pend = 0; cur = 0;
    ss_gnt = 0; ss_rvalid = 0; ss_rdata = '0; ss_err = 0;
    forever begin
      @(negedge clk);
      ss_gnt = 0; ss_rvalid = 0; ss_err = 0;
      if (reset) begin
        pend = 0;
      end else begin
        if (pend && rv_en) begin
          ss_rvalid = 1;
          ss_rdata  = rd_tab[cur[3:0]];
          ss_err    = (cur == err_at);
          pend      = 0;
        end
        if (ss_req && !pend) begin
          ss_gnt = 1;
          cur    = n_req;
          if (n_req < 512) begin
            log_addr[n_req[8:0]]  = ss_addr;
            log_wdata[n_req[8:0]] = ss_wdata;
            log_be[n_req[8:0]]    = ss_be;
            log_we[n_req[8:0]]    = ss_we;
          end
          n_req++;
          pend = 1;
        end
      end
    end
  end

  // ---------------- AXI master tasks ----------------
  logic [31:0] rdat [256];
  logic [31:0] rhold[256];
  logic [1:0]  rrsp [256];
  logic        rlst [256];

  task automatic ar_hs(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b);
    int k;
    @(negedge clk);
    S_AXI_ARADDR = a; S_AXI_ARLEN = len; S_AXI_ARBURST = b; S_AXI_ARSIZE = 3'd2;
    S_AXI_ARVALID = 1;
    for (k = 0; k < TMO; k++) begin
      #1;
      if (S_AXI_ARREADY) break;
      @(negedge clk);
    end
    if (k == TMO) chk("ar_hs_timeout", 32'(S_AXI_ARREADY), 32'd1);
    @(posedge clk);
    #1 S_AXI_ARVALID = 0;
  endtask

  task automatic aw_hs(input logic [31:0] a, input logic [7:0] len, input logic [1:0] b);
    int k;
    @(negedge clk);
    S_AXI_AWADDR = a; S_AXI_AWLEN = len; S_AXI_AWBURST = b; S_AXI_AWSIZE = 3'd2;
    S_AXI_AWVALID = 1;
    for (k = 0; k < TMO; k++) begin
      #1;
      if (S_AXI_AWREADY) break;
      @(negedge clk);
    end
    if (k == TMO) chk("aw_hs_timeout", 32'(S_AXI_AWREADY), 32'd1);
    @(posedge clk);
    #1 S_AXI_AWVALID = 0;
  endtask

  // Waits for RVALID, records the beat, optionally holds RREADY low for
  // 'stall' cycles, then completes the handshake. lat counts negedges.
  task automatic rd_beat(input int idx, input int stall, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!S_AXI_RVALID && lat < TMO);
    if (!S_AXI_RVALID) chk("rvalid_timeout", 32'(S_AXI_RVALID), 32'd1);
    rdat[idx] = S_AXI_RDATA; rrsp[idx] = S_AXI_RRESP; rlst[idx] = S_AXI_RLAST;
    if (stall > 0) begin
      S_AXI_RREADY = 0;
      repeat (stall) @(negedge clk);
      chk("stall_rvalid", 32'(S_AXI_RVALID), 32'd1);
      rhold[idx] = S_AXI_RDATA;
      S_AXI_RREADY = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic w_beat(input logic [31:0] d, input logic [3:0] s, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!S_AXI_WREADY && lat < TMO);
    if (!S_AXI_WREADY) chk("wready_timeout", 32'(S_AXI_WREADY), 32'd1);
    S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WLAST = 0; S_AXI_WVALID = 1;
    @(posedge clk);
    #1 S_AXI_WVALID = 0;
  endtask

  task automatic b_wait(output logic [1:0] resp, output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!S_AXI_BVALID && lat < TMO);
    if (!S_AXI_BVALID) chk("bvalid_timeout", 32'(S_AXI_BVALID), 32'd1);
    resp = S_AXI_BRESP;
    S_AXI_BREADY = 1;
    @(posedge clk);
    #1 S_AXI_BREADY = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    int base, lat, nlast;
    logic [1:0] br;
    logic got_r, got_w;
    logic [31:0] wd[3];

    reset = 1;
    S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0; S_AXI_AWBURST = '0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARSIZE = '0; S_AXI_ARBURST = '0; S_AXI_ARVALID = 0;
    S_AXI_RREADY = 1;
    for (int i = 0; i < 16; i++) rd_tab[i] = 32'h0;
    repeat (3) @(negedge clk);
    #1 reset = 0;
    @(negedge clk);

    // reset state
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_wready",  32'(S_AXI_WREADY), 32'd0);
    chk("rst_rvalid",  32'(S_AXI_RVALID), 32'd0);
    chk("rst_bvalid",  32'(S_AXI_BVALID), 32'd0);
    chk("rst_rlast",   32'(S_AXI_RLAST), 32'd0);
    chk("rst_ss_req",  32'(ss_req), 32'd0);
    chk("rst_ss_we",   32'(ss_we), 32'd0);
    chk("rst_ss_be",   32'(ss_be), 32'd0);
    chk("rst_ss_addr", ss_addr, 32'd0);
    chk("rst_rdata",   S_AXI_RDATA, 32'd0);
    chk("rst_resp",    32'({S_AXI_RRESP, S_AXI_BRESP}), 32'd0);

    // arbitration: both valid for four transactions, read wins first
    S_AXI_ARADDR = 32'h400; S_AXI_ARLEN = 0; S_AXI_ARBURST = INCR; S_AXI_ARSIZE = 3'd2;
    S_AXI_AWADDR = 32'h500; S_AXI_AWLEN = 0; S_AXI_AWBURST = INCR; S_AXI_AWSIZE = 3'd2;
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      S_AXI_ARVALID = 1; S_AXI_AWVALID = 1;
      #1;
      got_r = S_AXI_ARREADY; got_w = S_AXI_AWREADY;
      chk($sformatf("arb%0d_rd", r), 32'(got_r), 32'(r % 2 == 0));
      chk($sformatf("arb%0d_wr", r), 32'(got_w), 32'(r % 2 == 1));
      @(posedge clk);
      #1;
      if (got_r) begin
        S_AXI_ARVALID = 0;
        rd_beat(0, 0, lat);
      end else if (got_w) begin
        S_AXI_AWVALID = 0;
        w_beat(32'h55, 4'hF, lat);
        b_wait(br, lat);
      end
    end
    S_AXI_ARVALID = 0; S_AXI_AWVALID = 0;

    // single read
    base = n_req;
    rd_tab[4'(base)] = 32'h0000_00A5;
    ar_hs(32'h9A10_0010, 8'd0, INCR);
    rd_beat(0, 0, lat);
    chk("t1_latency", lat, 32'd3);
    chk("t1_rdata", rdat[0], 32'hA5);
    chk("t1_rresp", 32'(rrsp[0]), 32'd0);
    chk("t1_rlast", 32'(rlst[0]), 32'd1);
    chk("t1_nreq", n_req - base, 32'd1);
    chk("t1_addr", log_addr[9'(base)], 32'h9A10_0010);
    chk("t1_we_be", 32'({log_we[9'(base)], log_be[9'(base)]}), 32'h0F);
    @(negedge clk);
    chk("t1_rvalid_drop", 32'(S_AXI_RVALID), 32'd0);

    // 4-beat INCR read with a 2-cycle RREADY stall on beat 2
    base = n_req;
    for (int i = 0; i < 4; i++) rd_tab[4'(base + i)] = 32'hC0DE_0000 + i;
    ar_hs(32'h100, 8'd3, INCR);
    for (int i = 0; i < 4; i++) begin
      rd_beat(i, (i == 1) ? 2 : 0, lat);
      chk($sformatf("t2_lat%0d", i), lat, 32'd3);
    end
    chk("t2_nreq", n_req - base, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_addr%0d", i), log_addr[9'(base + i)], 32'h100 + 32'(4 * i));
      chk($sformatf("t2_rdata%0d", i), rdat[i], 32'hC0DE_0000 + i);
      chk($sformatf("t2_rlast%0d", i), 32'(rlst[i]), 32'(i == 3));
    end
    chk("t2_stall_hold", rhold[1], 32'hC0DE_0001);

    // FIXED write burst
    base = n_req;
    wd[0] = 32'h41; wd[1] = 32'h42; wd[2] = 32'h43;
    aw_hs(32'h9A10_0014, 8'd2, FIXED);
    for (int i = 0; i < 3; i++) begin
      w_beat(wd[i], 4'b0001, lat);
      chk($sformatf("t3_wready_lat%0d", i), lat, (i == 0) ? 32'd1 : 32'd3);
    end
    b_wait(br, lat);
    chk("t3_bvalid_lat", lat, 32'd3);
    chk("t3_bresp", 32'(br), 32'd0);
    chk("t3_nreq", n_req - base, 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t3_addr%0d", i), log_addr[9'(base + i)], 32'h9A10_0014);
      chk($sformatf("t3_we_be%0d", i), 32'({log_we[9'(base + i)], log_be[9'(base + i)]}), 32'h11);
      chk($sformatf("t3_wdata%0d", i), log_wdata[9'(base + i)], wd[i]);
    end

    // error on beat 2 of 3, then a clean write
    base = n_req;
    err_at = base + 1;
    aw_hs(32'h300, 8'd2, INCR);
    for (int i = 0; i < 3; i++) w_beat(32'hE0 + i, 4'hF, lat);
    b_wait(br, lat);
    chk("t4_bresp_err", 32'(br), 32'd2);
    chk("t4_nreq", n_req - base, 32'd3);
    chk("t4_addr2", log_addr[9'(base + 2)], 32'h308);
    err_at = -1;
    aw_hs(32'h310, 8'd0, INCR);
    w_beat(32'h77, 4'hF, lat);
    b_wait(br, lat);
    chk("t4_bresp_clean", 32'(br), 32'd0);

    // address wrap-around at 2^AW
    base = n_req;
    ar_hs(32'hFFFF_FFFC, 8'd1, INCR);
    rd_beat(0, 0, lat);
    rd_beat(1, 0, lat);
    chk("wrap_addr0", log_addr[9'(base)], 32'hFFFF_FFFC);
    chk("wrap_addr1", log_addr[9'(base + 1)], 32'h0);

    // LEN=255 gives 256 beats, RLAST only on the last one
    base = n_req;
    for (int i = 0; i < 16; i++) rd_tab[i] = 32'hB000_0000 + i;
    ar_hs(32'h1000, 8'd255, INCR);
    nlast = 0;
    for (int i = 0; i < 256; i++) begin
      rd_beat(i, 0, lat);
      if (rlst[i]) nlast++;
    end
    chk("l255_nreq", n_req - base, 32'd256);
    chk("l255_nlast", nlast, 32'd1);
    chk("l255_rlast", 32'(rlst[255]), 32'd1);
    chk("l255_addr", log_addr[9'(base + 255)], 32'h13FC);
    chk("l255_rdata", rdat[255], 32'hB000_0000 + 32'(4'(base + 255)));

    // reset in RD_WAIT on beat 2 of 4
    base = n_req;
    rd_tab[4'(base)] = 32'h1111_2222;
    ar_hs(32'h600, 8'd3, INCR);
    rd_beat(0, 0, lat);
    rv_en = 0;
    lat = 0;
    do begin @(negedge clk); #1; lat++; end while (n_req < base + 2 && lat < TMO);
    if (n_req < base + 2) chk("rst_beat2_timeout", n_req - base, 32'd2);
    @(negedge clk);
    #1 reset = 1;
    #1;
    chk("mid_rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    chk("mid_rst_ss_req", 32'(ss_req), 32'd0);
    chk("mid_rst_ss_addr", ss_addr, 32'd0);
    chk("mid_rst_rdata", S_AXI_RDATA, 32'd0);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 0;
    rv_en = 1;
    base = n_req;
    rd_tab[4'(base)] = 32'h0BAD_F00D;
    ar_hs(32'h700, 8'd0, INCR);
    rd_beat(0, 0, lat);
    chk("post_rst_lat", lat, 32'd3);
    chk("post_rst_rdata", rdat[0], 32'h0BAD_F00D);
    chk("post_rst_rlast", 32'(rlst[0]), 32'd1);
    chk("post_rst_addr", log_addr[9'(base)], 32'h700);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/axi_ss_bridge.md
# axi_ss_bridge

AXI4 slave that terminates the core's AXI master port and converts each AXI beat into a single-beat transaction on the simple peripheral bus (req/gnt/rvalid, we, be, addr, wdata, rdata, err) used by the UART and other memory-mapped peripherals. It replaces the tie-off glue in the FPGA top with real handshakes, bursts, back-pressure and error reporting. One transaction (read or write burst) is in service at a time, with one outstanding beat on the peripheral bus.

## Interface
- AW, 32, address width (AXI and peripheral bus)
- DW, 32, data width; fixed at 32, WSTRB/ss_be are 4 bits
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- S_AXI_AWADDR/AWLEN/AWSIZE/AWBURST  in  AW/8/3/2  write address channel
- S_AXI_AWVALID in 1 / S_AXI_AWREADY out 1  write address handshake
- S_AXI_WDATA/WSTRB/WLAST  in  DW/4/1  write data; WLAST ignored, beat count from AWLEN
- S_AXI_WVALID in 1 / S_AXI_WREADY out 1  write data handshake
- S_AXI_BRESP out 2 / S_AXI_BVALID out 1 / S_AXI_BREADY in 1  write response
- S_AXI_ARADDR/ARLEN/ARSIZE/ARBURST  in  AW/8/3/2  read address channel
- S_AXI_ARVALID in 1 / S_AXI_ARREADY out 1  read address handshake
- S_AXI_RDATA out DW / RRESP out 2 / RLAST out 1 / RVALID out 1 / RREADY in 1  read data
- ss_req out 1 / ss_we out 1 / ss_be out 4 / ss_addr out AW / ss_wdata out DW  peripheral request
- ss_gnt in 1  request accepted this cycle
- ss_rvalid in 1 / ss_rdata in DW / ss_err in 1  response (for reads and writes), ≥1 cycle after gnt

## Operation
- States: IDLE, RD_REQ, RD_WAIT, RD_OUT, WR_DATA, WR_REQ, WR_WAIT, WR_RESP.
- IDLE: ARREADY/AWREADY driven combinationally from state and arbitration. If only one of ARVALID/AWVALID is high, that channel is served. If both are high, the channel not served last wins (alternating; after reset, read wins). The handshake captures addr, len, burst; beat counter := LEN.
- Read: RD_REQ drives ss_req=1, ss_we=0, ss_be=4'hF; held with stable addr until ss_gnt, then RD_WAIT. On ss_rvalid, RDATA := ss_rdata; RRESP := ss_err ? 2'b10 : 2'b00; RVALID := 1; RLAST := (counter==0); go to RD_OUT. On RVALID&RREADY: if last, go to IDLE, else decrement counter, advance address, go to RD_REQ.
- Write: WR_DATA drives WREADY=1; on WVALID it latches WDATA/WSTRB and goes to WR_REQ (ss_we=1, ss_be=latched WSTRB), held until ss_gnt, then WR_WAIT. On ss_rvalid, sticky error |= ss_err. Then: if last, go to WR_RESP, else decrement counter, advance address, go to WR_DATA.
- WR_RESP: BVALID=1, BRESP = sticky ? 2'b10 : 2'b00; on BREADY, clear sticky and go to IDLE.
- Address advance: INCR and WRAP add 4, with AW-bit wrap-around at 2^AW; FIXED keeps the address. WRAP is treated as INCR. AxSIZE is ignored (32-bit beats only); low address bits pass through unmodified.
- ss_rvalid outside RD_WAIT/WR_WAIT is ignored. ss_gnt while ss_req=0 is ignored.

## Timing
- Reset values: all READY/VALID, ss_req, ss_we, RLAST = 0; RDATA, ss_addr, ss_wdata = 0; ss_be = 0; RRESP/BRESP = 0; state IDLE; arbitration points to read.
- Read: AR handshake in cycle N → ss_req in N+1. Gnt in N+1 and rvalid in N+2 → RVALID in N+3. Each following beat adds 3 cycles plus RREADY stall cycles.
- Write: AW handshake in N → WREADY in N+1. W handshake in M → ss_req in M+1. rvalid in M+2 → next WREADY (or BVALID) in M+3.
- ss_addr/ss_we/ss_be/ss_wdata are registered and stable for the whole time ss_req is high; ss_req is never dropped before gnt.
- RVALID/RDATA/RRESP/RLAST and BVALID/BRESP are stable until the handshake completes.
- Reset asserted mid-burst: outputs return to reset values immediately (async); the in-flight peripheral transaction and remaining beats are abandoned.
- LEN=255 → 256 beats; the counter never underflows.

## Test plan
- Single read: ARADDR=0x9A10_0010, ARLEN=0, ss_gnt same cycle, ss_rvalid next cycle with rdata 0x0000_00A5 → RDATA=0xA5, RRESP=0, RLAST=1, RVALID 3 cycles after AR handshake.
- 4-beat INCR read at 0x100 with RREADY low for 2 cycles on beat 2 → ss_addr sequence 0x100, 0x104, 0x108, 0x10C; RLAST only on beat 4; RDATA held during the stall.
- Write, FIXED burst, AWLEN=2, WSTRB=4'b0001, data 0x41/0x42/0x43 to 0x9A10_0014 → three ss writes, all to 0x9A10_0014 with be=0001; BRESP=0.
- ss_err on beat 2 of a 3-beat write → all 3 beats issued; BRESP=2'b10; the next write returns BRESP=0.
- ARVALID and AWVALID high together for 4 transactions → served read, write, read, write.
- Reset pulsed while in RD_WAIT on beat 2 of 4 → RVALID and ss_req 0 at once; the next AR is accepted from IDLE normally.
